// File: rtl/arcade_input_if.sv
// Bundle of keyboard, joystick and option inputs plus the merged control
// outputs exchanged between user_io (master) and arcade_input_mux (slave).
interface arcade_input_if #(
  parameter int unsigned PLAYERS = 2,
  parameter int unsigned BUTTONS = 6
);
  logic                              key_strobe;
  logic                              key_pressed;
  logic                              key_extended;
  logic [7:0]                        key_code;
  logic [PLAYERS*32-1:0]             joy_in;
  logic                              rotate;
  logic [1:0]                        orientation;
  logic                              joyswap;
  logic [PLAYERS-1:0]                autofire_en;
  logic [8:0]                        controls;
  logic [PLAYERS*(BUTTONS+4)-1:0]    players;

  modport master (
    output key_strobe, key_pressed, key_extended, key_code, joy_in,
           rotate, orientation, joyswap, autofire_en,
    input  controls, players
  );

  modport slave (
    input  key_strobe, key_pressed, key_extended, key_code, joy_in,
           rotate, orientation, joyswap, autofire_en,
    output controls, players
  );
endinterface

// File: rtl/arcade_input_mux.sv
// Merges PS/2 key state and MiST joystick words into per-player vectors with
// rotation, joystick swap, coin pulse shaping and per-player autofire.
module arcade_input_mux #(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned BUTTONS      = 6,
  parameter int unsigned COIN_PULSE   = 240000,
  parameter int unsigned AUTOFIRE_DIV = 1200000
) (
  input logic           clk,
  input logic           reset,
  arcade_input_if.slave bus
);
  localparam int unsigned PW = BUTTONS + 4;
  localparam int unsigned KW = 29;
  localparam int unsigned KB = (BUTTONS < 6) ? BUTTONS : 6;
  localparam int unsigned CW = (COIN_PULSE   > 1) ? $clog2(COIN_PULSE)   : 1;
  localparam int unsigned AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_HOLD} coin_state_t;

  // Key state layout: per player 10 bits in joystick order, then starts, coins, tilt
  logic [KW-1:0] r_keys;
  logic          w_key_hit;
  logic [4:0]    w_key_idx;

  always_comb begin
    w_key_hit = 1'b1;
    w_key_idx = 5'd0;
    case ({bus.key_extended, bus.key_code})
      9'h174: w_key_idx = 5'd0;   9'h16B: w_key_idx = 5'd1;
      9'h172: w_key_idx = 5'd2;   9'h175: w_key_idx = 5'd3;
      9'h014: w_key_idx = 5'd4;   9'h011: w_key_idx = 5'd5;
      9'h029: w_key_idx = 5'd6;   9'h012: w_key_idx = 5'd7;
      9'h01A: w_key_idx = 5'd8;   9'h022: w_key_idx = 5'd9;
      9'h034: w_key_idx = 5'd10;  9'h023: w_key_idx = 5'd11;
      9'h02B: w_key_idx = 5'd12;  9'h02D: w_key_idx = 5'd13;
      9'h01C: w_key_idx = 5'd14;  9'h01B: w_key_idx = 5'd15;
      9'h015: w_key_idx = 5'd16;  9'h01D: w_key_idx = 5'd17;
      9'h043: w_key_idx = 5'd18;  9'h042: w_key_idx = 5'd19;
      9'h016: w_key_idx = 5'd20;  9'h01E: w_key_idx = 5'd21;
      9'h026: w_key_idx = 5'd22;  9'h025: w_key_idx = 5'd23;
      9'h02E: w_key_idx = 5'd24;  9'h036: w_key_idx = 5'd25;
      9'h03D: w_key_idx = 5'd26;  9'h03E: w_key_idx = 5'd27;
      9'h02C: w_key_idx = 5'd28;
      default: w_key_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_keys <= '0;
    else if (bus.key_strobe && w_key_hit)  r_keys[w_key_idx] <= bus.key_pressed;
  end

  // Raw per-player vectors, joystick start/coin bits
  logic [31:0]   w_src   [PLAYERS];
  logic [PW-1:0] w_kb    [PLAYERS];
  logic [PW-1:0] w_raw   [PLAYERS];
  logic [3:0]    w_jstart, w_jcoin;

  always_comb begin
    w_jstart = 4'd0;
    w_jcoin  = 4'd0;
    for (int p = 0; p < int'(PLAYERS); p++) begin
      int s;
      int kbase;
      s = (bus.joyswap && PLAYERS > 1 && p < 2) ? (p ^ 1) : p;
      kbase = (p < 2) ? 10 * p : 0;
      w_src[p] = bus.joy_in[32*s +: 32];
      w_kb[p]  = '0;
      if (p < 2) begin
        w_kb[p][3:0] = r_keys[kbase +: 4];
        for (int k = 0; k < int'(KB); k++) w_kb[p][4+k] = r_keys[kbase+4+k];
      end
      w_raw[p]    = w_src[p][PW-1:0] | w_kb[p];
      w_jstart[p] = w_src[p][28];
      w_jcoin[p]  = w_src[p][29];
    end
  end

  // Autofire on button A
  logic          r_af_out  [PLAYERS];
  logic          r_af_prev [PLAYERS];
  logic [AW-1:0] r_af_cnt  [PLAYERS];
  logic          w_af_out_n [PLAYERS];
  logic [AW-1:0] w_af_cnt_n [PLAYERS];

  always_comb begin
    for (int p = 0; p < int'(PLAYERS); p++) begin
      w_af_out_n[p] = w_raw[p][4];
      w_af_cnt_n[p] = '0;
      if (bus.autofire_en[p] && w_raw[p][4]) begin
        if (!r_af_prev[p]) begin
          w_af_out_n[p] = 1'b1;
        end else if (r_af_cnt[p] == AW'(AUTOFIRE_DIV - 1)) begin
          w_af_out_n[p] = ~r_af_out[p];
        end else begin
          w_af_out_n[p] = r_af_out[p];
          w_af_cnt_n[p] = r_af_cnt[p] + AW'(1);
        end
      end
    end
  end

  // Coin shapers: next state and registered output
  coin_state_t   r_cst  [4];
  coin_state_t   w_cst_n [4];
  logic [CW-1:0] r_ccnt [4];
  logic [CW-1:0] w_ccnt_n [4];
  logic [3:0]    w_coin_raw, w_coin_n;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_coin_raw[c] = r_keys[24+c] | w_jcoin[c];
      w_cst_n[c]    = r_cst[c];
      w_ccnt_n[c]   = r_ccnt[c];
      w_coin_n[c]   = 1'b0;
      case (r_cst[c])
        C_IDLE: if (w_coin_raw[c]) begin
          w_cst_n[c]  = C_PULSE;
          w_ccnt_n[c] = CW'(COIN_PULSE - 1);
          w_coin_n[c] = 1'b1;
        end
        C_PULSE: if (r_ccnt[c] == '0) begin
          w_cst_n[c] = w_coin_raw[c] ? C_HOLD : C_IDLE;
        end else begin
          w_ccnt_n[c] = r_ccnt[c] - CW'(1);
          w_coin_n[c] = 1'b1;
        end
        C_HOLD: if (!w_coin_raw[c]) w_cst_n[c] = C_IDLE;
        default: w_cst_n[c] = C_IDLE;
      endcase
    end
  end

  // Rotation and final player vectors
  logic [PLAYERS*PW-1:0] w_players_n;
  always_comb begin
    w_players_n = '0;
    for (int p = 0; p < int'(PLAYERS); p++) begin
      logic u, d, l, r;
      logic [PW-1:0] pv;
      {u, d, l, r} = w_raw[p][3:0];
      if (bus.rotate) begin
        if (!bus.orientation[0]) {u, d, l, r} = {w_raw[p][1], w_raw[p][0], w_raw[p][2], w_raw[p][3]};
        else                     {u, d, l, r} = {w_raw[p][0], w_raw[p][1], w_raw[p][3], w_raw[p][2]};
      end
      if (bus.orientation[1]) {u, d, l, r} = {d, u, r, l};
      pv       = w_raw[p];
      pv[3:0]  = {u, d, l, r};
      pv[4]    = w_af_out_n[p];
      w_players_n[PW*p +: PW] = pv;
    end
  end

  logic [8:0]            r_controls;
  logic [PLAYERS*PW-1:0] r_players;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_controls <= '0;
      r_players  <= '0;
      for (int c = 0; c < 4; c++) begin
        r_cst[c]  <= C_IDLE;
        r_ccnt[c] <= '0;
      end
      for (int p = 0; p < int'(PLAYERS); p++) begin
        r_af_out[p]  <= 1'b0;
        r_af_prev[p] <= 1'b0;
        r_af_cnt[p]  <= '0;
      end
    end else begin
      r_controls <= {r_keys[28], w_coin_n, r_keys[23:20] | w_jstart};
      r_players  <= w_players_n;
      for (int c = 0; c < 4; c++) begin
        r_cst[c]  <= w_cst_n[c];
        r_ccnt[c] <= w_ccnt_n[c];
      end
      for (int p = 0; p < int'(PLAYERS); p++) begin
        r_af_out[p]  <= w_af_out_n[p];
        r_af_prev[p] <= w_raw[p][4];
        r_af_cnt[p]  <= w_af_cnt_n[p];
      end
    end
  end

  assign bus.controls = r_controls;
  assign bus.players  = r_players;

  // Joystick bits outside the mapped set are intentionally ignored
  logic w_unused;
  assign w_unused = ^{bus.joy_in, r_keys};
endmodule

// File: doc/arcade_input_mux.md
# arcade_input_mux

Parametrised input front end for MiST arcade cores. It merges PS/2 keyboard events and up to four MiST joystick words into per-player direction and button vectors plus shared start, coin and tilt controls. It applies screen-rotation remapping, joystick swap, coin pulse shaping and per-player autofire. It sits between user_io and the arcade core, clocked on the system clock.

## Interface
- PLAYERS, 2, number of player vectors (1..4)
- BUTTONS, 6, fire buttons per player (1..12)
- COIN_PULSE, 240000, coin output high time in clk cycles (≥1)
- AUTOFIRE_DIV, 1200000, autofire half-period in clk cycles (≥1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_strobe  in  1  one-cycle pulse: key_code/key_pressed/key_extended valid
- key_pressed  in  1  1 = make, 0 = break
- key_extended  in  1  1 = E0-prefixed scancode
- key_code  in  8  PS/2 set-2 scancode
- joy_in  in  PLAYERS*32  joystick words, word p at [32p+31:32p]
- rotate  in  1  enable 90° direction remap
- orientation  in  2  [0] 1 = CCW remap, 0 = CW; [1] 1 = additional 180° flip
- joyswap  in  1  swap joystick words 0 and 1 (ignored if PLAYERS=1)
- autofire_en  in  PLAYERS  per-player autofire on button A
- controls  out  9  {tilt, coin4..coin1, start4..start1}
- players  out  PLAYERS*(BUTTONS+4)  player p at [(BUTTONS+4)(p+1)-1:(BUTTONS+4)p] = {btn[BUTTONS-1:0], up, down, left, right}

## Operation
- Joystick word: bit0 right, 1 left, 2 down, 3 up, 4+k button k; bit 28 start(p); bit 29 coin(p). Other bits ignored.
- Keyboard state register: one bit per mapped key, set on make, cleared on break, updated only on key_strobe. Extended and non-extended codes are distinct keys. Unmapped codes are ignored.
- Key map (only players 1 and 2; buttons beyond BUTTONS dropped):
  - P1 directions: ext 75 up, ext 72 down, ext 6B left, ext 74 right. Buttons A..F: 14, 11, 29, 12, 1A, 22.
  - P2 directions: 2D up, 2B down, 23 left, 34 right. Buttons A..F: 1C, 1B, 15, 1D, 43, 42.
  - Starts 1..4: 16, 1E, 26, 25. Coins 1..4: 2E, 36, 3D, 3E. Tilt: 2C.
- Raw player p = keyboard(p) OR joystick source(p). The source is word p, except words 0 and 1 exchange when joyswap=1.
- Rotation is applied to merged directions, in this order:
  - rotate=1, orientation[0]=0: up←left, down←right, left←down, right←up.
  - rotate=1, orientation[0]=1: up←right, down←left, left←up, right←down.
  - Then, if orientation[1]=1 (independent of rotate), swap up/down and left/right.
- Starts 1..4 and tilt pass through unshaped. Starts/coins for index ≥PLAYERS come from keyboard only.
- Coin shaper, per coin, state IDLE/PULSE/HOLD:
  - IDLE: raw rise → PULSE, counter loaded with COIN_PULSE-1, output 1.
  - PULSE: counter decrements; at 0, output 0 and go to HOLD if raw is still high, else IDLE.
  - HOLD: wait for raw=0, then go to IDLE.
  - Raw released during PULSE does not shorten the pulse. A held coin gives exactly one pulse.
- Autofire, per player with autofire_en=1:
  - Button A press (raw rise) forces output 1 and clears the phase counter.
  - While held, the output toggles each time the counter reaches AUTOFIRE_DIV-1; the counter then wraps to 0.
  - On release, output 0.
  - autofire_en=0: button A passes through. Enable changes take effect next cycle with the counter cleared.
- Counter widths: $clog2 of the parameter, minimum 1.

## Timing
- All outputs are registered.
- Joystick input → output: 1 cycle.
- key_strobe → output: 2 cycles (state register, then output register).
- Coin: output rises 1 cycle after raw rises and is high for exactly COIN_PULSE cycles.
- Autofire: output high for AUTOFIRE_DIV cycles, then low for AUTOFIRE_DIV cycles, repeating.
- Reset (asynchronous, any time, including mid-pulse or mid-autofire):
  - Key state, shapers, counters and all outputs go to 0; shapers return to IDLE.
  - After release, an input already held is treated as a fresh rise.
- A simultaneous keyboard make and joystick release on the same bit leaves the merged bit 1.

## Test plan
- Reset, then joy_in word0 bit3=1 → players[3] (P1 up) = 1 after 1 cycle; with rotate=1, orientation=0 → players[0] (P1 right) = 1, up = 0.
- key_strobe with make, ext=1, code 75 → P1 up = 1 two cycles later. Break → 0. Non-extended 75 → no change.
- COIN_PULSE=4: key 2E held 20 cycles → controls[4] high for exactly 4 cycles, once. Release then press again → second 4-cycle pulse.
- AUTOFIRE_DIV=3, autofire_en[0]=1, hold P1 button A for 13 cycles → output pattern 1,1,1,0,0,0,1,1,1,0,0,0,1. Release → 0 next cycle.
- joyswap=1, word1 bit4=1 → P1 button A = 1, P2 button A = 0.
- Assert reset during a coin pulse (coin still held) → controls = 0 immediately. After release, a new 4-cycle pulse is issued.
